// File: rtl/layer3_seq.sv
// Layer-3 fully-connected sequencer: for every output neuron it streams
// activations and weights into the PE, waits for the PE result, writes it
// to the output buffer and clears the PE. Data passes through unmodified.
module layer3_seq #(
    parameter int IN_LEN      = 256,
    parameter int OUT_NUM     = 120,
    parameter int FIN_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  act_addr,
    input  logic [17:0] act_rdata,
    output logic [14:0] w_addr,
    input  logic [15:0] w_rdata,
    output logic [6:0]  b_addr,
    input  logic [15:0] b_rdata,
    output logic [17:0] pe_din1,
    output logic [15:0] pe_din2,
    output logic [15:0] pe_bias,
    output logic        pe_ena,
    output logic        pe_clr,
    input  logic [15:0] pe_dout,
    input  logic        pe_finish,
    output logic [6:0]  out_waddr,
    output logic [15:0] out_wdata,
    output logic        out_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int              WC_W    = $clog2(FIN_TIMEOUT) + 1;
    localparam logic [7:0]      K_LAST  = 8'(IN_LEN - 1);
    localparam logic [6:0]      N_LAST  = 7'(OUT_NUM - 1);
    localparam logic [WC_W-1:0] TO_LAST = WC_W'(FIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_BIAS, STREAM, DRAIN, WAIT_FIN, WRITE, CLEAR, FINISH
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      k;
    logic [6:0]      neuron;
    logic [WC_W-1:0] wait_cnt;
    logic            issue;

    // State register; reset abandons any pass in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = LOAD_BIAS;
            LOAD_BIAS: state_nxt = STREAM;
            STREAM:    if (k == K_LAST) state_nxt = DRAIN;
            DRAIN:     state_nxt = WAIT_FIN;
            WAIT_FIN: begin
                if (pe_finish)               state_nxt = WRITE;
                else if (wait_cnt == TO_LAST) state_nxt = FINISH;
            end
            WRITE:     state_nxt = CLEAR;
            CLEAR:     state_nxt = (neuron == N_LAST) ? FINISH : LOAD_BIAS;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Moore outputs plus the combinational data pass-through to the PE.
    always_comb begin
        issue    = (state == STREAM);
        pe_clr   = (state == IDLE) || (state == CLEAR) || (state == FINISH);
        out_we   = (state == WRITE);
        busy     = (state != IDLE);
        done     = (state == FINISH);
        act_addr = k;
        b_addr   = neuron;
        pe_din1  = act_rdata;
        pe_din2  = w_rdata;
    end

    // Counters, addresses, captured bias/result and the sticky error flag.
    // pe_ena lags the issue strobe by the one-cycle memory read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k         <= '0;
            neuron    <= '0;
            w_addr    <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            pe_bias   <= '0;
            out_wdata <= '0;
            out_waddr <= '0;
            pe_ena    <= 1'b0;
        end else begin
            pe_ena <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        neuron <= '0;
                        w_addr <= '0;
                        err    <= 1'b0;
                    end
                end
                LOAD_BIAS: k <= '0;
                STREAM: begin
                    k        <= k + 8'd1;
                    wait_cnt <= '0;
                    // Weight address runs contiguously across neurons and
                    // only returns to zero after the final neuron.
                    if (k == K_LAST && neuron == N_LAST) w_addr <= '0;
                    else                                 w_addr <= w_addr + 15'd1;
                    // Bias ROM data arrives in the first stream cycle.
                    if (k == 8'd0) pe_bias <= b_rdata;
                end
                WAIT_FIN: begin
                    wait_cnt <= wait_cnt + WC_W'(1);
                    if (pe_finish) begin
                        out_wdata <= pe_dout;
                        out_waddr <= neuron;
                    end else if (wait_cnt == TO_LAST) begin
                        err <= 1'b1;
                    end
                end
                CLEAR: if (neuron != N_LAST) neuron <= neuron + 7'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_layer3_seq.sv
// Directed bench for layer3_seq with behavioural memories and a PE model.
module tb_layer3_seq;

    localparam int IN_LEN  = 256;
    localparam int OUT_NUM = 120;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  act_addr;
    logic [17:0] act_rdata;
    logic [14:0] w_addr;
    logic [15:0] w_rdata;
    logic [6:0]  b_addr;
    logic [15:0] b_rdata;
    logic [17:0] pe_din1;
    logic [15:0] pe_din2;
    logic [15:0] pe_bias;
    logic        pe_ena;
    logic        pe_clr;
    logic [15:0] pe_dout;
    logic        pe_finish;
    logic [6:0]  out_waddr;
    logic [15:0] out_wdata;
    logic        out_we;
    logic        busy;
    logic        done;
    logic        err;

    layer3_seq #(.IN_LEN(IN_LEN), .OUT_NUM(OUT_NUM), .FIN_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .start(start),
        .act_addr(act_addr), .act_rdata(act_rdata),
        .w_addr(w_addr), .w_rdata(w_rdata),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .pe_din1(pe_din1), .pe_din2(pe_din2), .pe_bias(pe_bias),
        .pe_ena(pe_ena), .pe_clr(pe_clr), .pe_dout(pe_dout), .pe_finish(pe_finish),
        .out_waddr(out_waddr), .out_wdata(out_wdata), .out_we(out_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous memories
    logic [17:0] amem [0:255];
    logic [15:0] wmem [0:30719];
    logic [15:0] bmem [0:127];

    always @(posedge clk) begin
        act_rdata <= amem[act_addr];
        w_rdata   <= wmem[w_addr];
        b_rdata   <= bmem[b_addr];
    end

    // PE model: accumulate while enabled, finish pulse after 256th product
    int          withhold = -1;
    int          acc = 0;
    int          acc_n;
    int          ecnt = 0;
    int          sum;
    logic        fin_m = 1'b0;
    logic [15:0] dout_m = '0;
    assign pe_finish = fin_m;
    assign pe_dout   = dout_m;

    always @(posedge clk) begin
        fin_m <= 1'b0;
        if (pe_clr) begin
            acc  <= 0;
            ecnt <= 0;
        end else if (pe_ena) begin
            acc_n = acc + $signed(pe_din1) * $signed(pe_din2);
            acc  <= acc_n;
            ecnt <= ecnt + 1;
            if (ecnt == IN_LEN - 1 && int'(b_addr) != withhold) begin
                sum = acc_n + $signed(pe_bias);
                fin_m  <= 1'b1;
                dout_m <= (sum < 0) ? 16'd0 : 16'(sum);
            end
        end
    end

    // Passive monitor, sampled on the falling edge
    logic [15:0] out_buf [0:127];
    int wr_cnt_at [0:127];
    int wr_total = 0, wr_addr_bad = 0, ena_bad = 0, bias_bad = 0;
    int lb_bad = 0, lb_total = 0, cur_n = 0, ena_run = 0, exp_n;
    int w_inc = 0, w_wrap = 0, w_bad = 0, w_max = 0;
    logic prev_busy = 1'b0, prev_clr = 1'b1;
    logic [14:0] prev_w = '0;

    initial for (int i = 0; i < 128; i++) wr_cnt_at[i] = 0;

    always @(negedge clk) begin
        if (pe_clr) ena_run = 0;
        else if (pe_ena) ena_run++;
        if (busy && !pe_clr && prev_clr) begin
            exp_n = prev_busy ? cur_n + 1 : 0;
            if (int'(b_addr) != exp_n) lb_bad++;
            cur_n = exp_n;
            lb_total++;
        end
        if (busy && (pe_ena || pe_finish) && pe_bias != bmem[b_addr]) bias_bad++;
        if (out_we) begin
            out_buf[out_waddr] = out_wdata;
            wr_cnt_at[out_waddr]++;
            wr_total++;
            if (int'(out_waddr) != cur_n) wr_addr_bad++;
            if (ena_run != IN_LEN) ena_bad++;
        end
        if (busy && prev_busy && w_addr != prev_w) begin
            if (w_addr == prev_w + 15'd1) w_inc++;
            else if (w_addr == 15'd0 && prev_w == 15'd30719) w_wrap++;
            else w_bad++;
        end
        if (busy && int'(w_addr) > w_max) w_max = int'(w_addr);
        prev_busy = busy;
        prev_clr  = pe_clr;
        prev_w    = w_addr;
    end

    typedef struct {
        int          addr;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [9];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int limit, input bit poke, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            start = poke && (cyc % 997 == 500);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_wait actual=no_done expected=done within %0d cycles", limit);
        end
    endtask

    initial begin
        int cyc, s_wr, s_w7;

        tbl[0] = '{0, 16'd266};   tbl[1] = '{1, 16'd266};
        tbl[2] = '{2, 16'd266};   tbl[3] = '{3, 16'd0};
        tbl[4] = '{4, 16'd266};   tbl[5] = '{7, 16'd266};
        tbl[6] = '{64, 16'd266};  tbl[7] = '{118, 16'd266};
        tbl[8] = '{119, 16'd266};

        for (int i = 0; i < 256; i++) amem[i] = 18'd1;
        for (int i = 0; i < 30720; i++)
            wmem[i] = (i >= 3 * IN_LEN && i < 4 * IN_LEN) ? 16'hFFFF : 16'd1;
        for (int i = 0; i < 128; i++) bmem[i] = (i == 3) ? 16'd0 : 16'd10;

        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_pe_ena", int'(pe_ena), 0);
        check("rst_pe_clr", int'(pe_clr), 1);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_out_we", int'(out_we), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_pe_bias", int'(pe_bias), 0);
        check("rst_out_wdata", int'(out_wdata), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", int'(busy), 0);

        // Full pass with stray start pulses during the pass
        launch();
        check("p1_busy", int'(busy), 1);
        check("p1_load_clr", int'(pe_clr), 0);
        run_until_done(40000, 1'b1, cyc);
        check("p1_done_latency", cyc, 31320);
        check("p1_err", int'(err), 0);
        check("p1_writes", wr_total, OUT_NUM);
        check("p1_waddr_seq", wr_addr_bad, 0);
        check("p1_ena_per_neuron", ena_bad, 0);
        check("p1_bias_stable", bias_bad, 0);
        check("p1_b_addr", lb_bad, 0);
        check("p1_loads", lb_total, OUT_NUM);
        check("p1_w_inc", w_inc, 30719);
        check("p1_w_wrap", w_wrap, 1);
        check("p1_w_bad", w_bad, 0);
        check("p1_w_max", w_max, 30719);
        for (int i = 0; i < 9; i++)
            check($sformatf("p1_out[%0d]", tbl[i].addr), int'(out_buf[tbl[i].addr]), int'(tbl[i].exp));

        // Start coincident with done is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_at_done_busy", int'(busy), 0);
        check("start_at_done_done", int'(done), 0);

        // Timeout on neuron 7; started one cycle after done
        withhold = 7;
        s_wr = wr_total;
        s_w7 = wr_cnt_at[7];
        launch();
        check("p2_busy", int'(busy), 1);
        run_until_done(5000, 1'b0, cyc);
        check("p2_done_latency", cyc, 2093);
        check("p2_err_at_done", int'(err), 1);
        check("p2_writes", wr_total - s_wr, 7);
        check("p2_no_write_7", wr_cnt_at[7] - s_w7, 0);
        @(posedge clk); #1;
        check("p2_busy_fall", int'(busy), 0);
        check("p2_err_sticky", int'(err), 1);

        // New start clears err; reset mid-stream of neuron 5
        withhold = -1;
        s_wr = wr_total;
        launch();
        check("p3_err_cleared", int'(err), 0);
        repeat (1400) @(posedge clk);
        #1;
        check("p3_mid_stream_ena", int'(pe_ena), 1);
        check("p3_mid_stream_neuron", int'(b_addr), 5);
        reset = 1'b0;
        #1;
        check("p3_rst_busy", int'(busy), 0);
        check("p3_rst_pe_ena", int'(pe_ena), 0);
        check("p3_rst_pe_clr", int'(pe_clr), 1);
        check("p3_rst_out_we", int'(out_we), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("p3_idle_after_rst", int'(busy), 0);
        check("p3_writes", wr_total - s_wr, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("p3_out[%0d]", tbl[i].addr), int'(out_buf[tbl[i].addr]), int'(tbl[i].exp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer3_seq.md
Name: layer3_seq

Overview:
- Sequencer directly upstream of the layer-3 fully-connected PE (256-input multiply-accumulate with bias and ReLU).
- Per output neuron it:
  - streams 256 activations (18-bit) and 256 weights (16-bit) from synchronous memories into the PE, with the neuron bias;
  - waits for the PE finish pulse;
  - writes the PE result to the layer-3 output buffer;
  - clears the PE.
- Runs all OUT_NUM neurons per start command.

Parameters:
- IN_LEN, 256, products per neuron; also the PE accumulate count.
- OUT_NUM, 120, neurons per layer pass.
- FIN_TIMEOUT, 8, maximum WAIT_FIN cycles before error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- act_addr  out  8  activation buffer read address.
- act_rdata  in  18  activation data, valid 1 cycle after act_addr.
- w_addr  out  15  weight ROM address = neuron*IN_LEN + k.
- w_rdata  in  16  weight data, valid 1 cycle after w_addr.
- b_addr  out  7  bias ROM address = neuron.
- b_rdata  in  16  bias data, valid 1 cycle after b_addr.
- pe_din1  out  18  combinational copy of act_rdata.
- pe_din2  out  16  combinational copy of w_rdata.
- pe_bias  out  16  registered bias for the current neuron.
- pe_ena  out  1  PE accumulate enable.
- pe_clr  out  1  active-high PE clear.
- pe_dout  in  16  PE result.
- pe_finish  in  1  PE result-valid pulse.
- out_waddr  out  7  output buffer write address.
- out_wdata  out  16  output buffer write data.
- out_we  out  1  output buffer write enable.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at end of pass.
- err  out  1  sticky timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters and addresses 0; pe_bias=0; out_wdata=0; pe_ena=0; out_we=0; busy=0; done=0; err=0; pe_clr=1.
- Reset mid-pass abandons the pass. Output-buffer entries already written stay written. The PE is held cleared by pe_clr=1.
- FSM states:
  - IDLE: pe_clr=1. On start: neuron=0, w_addr=0, err=0, go to LOAD_BIAS. start in any other state is ignored.
  - LOAD_BIAS (1 cycle): b_addr=neuron, pe_clr=0. Go to STREAM with k=0.
  - STREAM (IN_LEN cycles): present act_addr=k and w_addr. Increment k and w_addr each cycle. pe_ena is a registered copy of the issue strobe, so it is high exactly in the cycles where act_rdata and w_rdata are valid. pe_bias loads from b_rdata at the end of the first STREAM cycle and holds until the next LOAD_BIAS. After k=IN_LEN-1 go to DRAIN.
  - DRAIN (1 cycle): last pe_ena=1 cycle. Go to WAIT_FIN.
  - WAIT_FIN: pe_ena=0. If pe_finish=1, capture out_wdata<=pe_dout and out_waddr<=neuron, then go to WRITE. If FIN_TIMEOUT cycles pass without pe_finish, set err=1 and go to FINISH with no write.
  - WRITE (1 cycle): out_we=1. Go to CLEAR.
  - CLEAR (1 cycle): pe_clr=1. If neuron==OUT_NUM-1 go to FINISH; else neuron+1 and go to LOAD_BIAS.
  - FINISH (1 cycle): done=1, pe_clr=1. Go to IDLE.
- Exactly IN_LEN pe_ena cycles per neuron.
- The PE accumulates only while enabled; it asserts finish in the cycle after the last enabled cycle. Nominal WAIT_FIN dwell is therefore 1 cycle.
- Nominal per-neuron latency: 261 cycles (1+256+1+1+1+1).
- Full pass: 120×261 + 1 (FINISH) = 31321 cycles from the cycle after start to done.
- w_addr wraps only after the last neuron: max 30719.
- pe_finish outside WAIT_FIN is ignored.
- start in the same cycle as done: ignored. A new start is accepted from the following IDLE cycle.
- No arithmetic is done here. Data passes through unmodified; widths are fixed by the PE.

Test Plan:
- Reset with reset=0 mid-STREAM of neuron 5 -> busy=0, pe_ena=0, pe_clr=1 in the same cycle. Output entries 0..4 keep their values.
- Activations all 1, weights all 1, bias 10, PE model -> out_wdata=266 for every neuron. 120 out_we pulses at addresses 0..119. done exactly 31322 cycles after the start cycle.
- Neuron 3 with weights all -1, activations 1, bias 0 -> PE result 0 written at address 3. pe_ena high exactly 256 cycles per neuron (checked by counter).
- PE model withholds finish for neuron 7 -> err=1 after 8 WAIT_FIN cycles, no write to address 7, done pulses, busy falls. The next start clears err.
- start pulsed repeatedly during a pass -> no restart, no extra writes. start coincident with done -> ignored; start one cycle later -> new pass begins.
- Check w_addr sequence -> 0..30719 contiguous. b_addr=neuron in each LOAD_BIAS. pe_bias stable from the second STREAM cycle through WAIT_FIN.
